// File: rtl/text_console_writer.sv
// Teletype-style writer for the 80x25 text RAM: prints char/attr pairs,
// handles CR/LF/BS/FF, scrolls and clears the screen, and tracks the cursor.
module text_console_writer #(
  parameter int unsigned COLS = 80,
  parameter int unsigned ROWS = 25,
  parameter logic [7:0]  FILL = 8'h20
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  tx_data,
  input  logic [7:0]  tx_attr,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        busy,
  output logic [10:0] cursor,
  output logic [12:0] mem_address,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  input  logic [7:0]  mem_rdata
);

  localparam int unsigned RW = $clog2(ROWS);
  localparam int unsigned CW = $clog2(COLS);
  localparam int unsigned AW = 13;
  localparam logic [AW-1:0] ROW_BYTES = AW'(2 * COLS);
  localparam logic [AW-1:0] COPY_LAST = AW'(2 * COLS * (ROWS - 1) - 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(2 * COLS * ROWS - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);

  typedef enum logic [2:0] {
    IDLE, WCHR, WATR, SCRL_RD, SCRL_WR, FILL_C, FILL_A
  } state_t;

  state_t        state_q;
  logic [RW-1:0] row_q;
  logic [CW-1:0] col_q;
  logic [10:0]   cursor_q;
  logic [AW-1:0] addr_q;
  logic [7:0]    wdata_q;
  logic [7:0]    attr_q;
  logic          we_q;
  logic          busy_q;
  logic          ready_q;
  logic          ff_q;

  function automatic logic [10:0] lin(input logic [RW-1:0] r, input logic [CW-1:0] c);
    return 11'(r) * 11'(COLS) + 11'(c);
  endfunction

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      row_q    <= '0;
      col_q    <= '0;
      cursor_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      attr_q   <= '0;
      we_q     <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
      ff_q     <= 1'b0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (tx_valid && ready_q) begin
            attr_q <= tx_attr;
            case (tx_data)
              8'h0D: begin
                col_q    <= '0;
                cursor_q <= lin(row_q, '0);
              end
              8'h08: begin
                if (col_q != '0) begin
                  col_q    <= CW'(col_q - 1'b1);
                  cursor_q <= lin(row_q, CW'(col_q - 1'b1));
                end
              end
              8'h0A: begin
                if (row_q != ROW_LAST) begin
                  row_q    <= RW'(row_q + 1'b1);
                  cursor_q <= lin(RW'(row_q + 1'b1), col_q);
                end else begin
                  state_q <= SCRL_RD;
                  busy_q  <= 1'b1;
                  ready_q <= 1'b0;
                  addr_q  <= ROW_BYTES;
                end
              end
              8'h0C: begin
                state_q <= FILL_C;
                ff_q    <= 1'b1;
                busy_q  <= 1'b1;
                ready_q <= 1'b0;
                addr_q  <= '0;
                wdata_q <= FILL;
                we_q    <= 1'b1;
              end
              default: begin
                state_q <= WCHR;
                ready_q <= 1'b0;
                addr_q  <= AW'({cursor_q, 1'b0});
                wdata_q <= tx_data;
                we_q    <= 1'b1;
              end
            endcase
          end
        end
        WCHR: begin
          state_q <= WATR;
          addr_q  <= AW'(addr_q + 1'b1);
          wdata_q <= attr_q;
          we_q    <= 1'b1;
        end
        WATR: begin
          // Wrapping past the last column implies a line feed in the same step.
          if (col_q == COL_LAST) begin
            col_q <= '0;
            if (row_q != ROW_LAST) begin
              row_q    <= RW'(row_q + 1'b1);
              cursor_q <= lin(RW'(row_q + 1'b1), '0);
              state_q  <= IDLE;
              ready_q  <= 1'b1;
            end else begin
              cursor_q <= lin(row_q, '0);
              state_q  <= SCRL_RD;
              busy_q   <= 1'b1;
              addr_q   <= ROW_BYTES;
            end
          end else begin
            col_q    <= CW'(col_q + 1'b1);
            cursor_q <= lin(row_q, CW'(col_q + 1'b1));
            state_q  <= IDLE;
            ready_q  <= 1'b1;
          end
        end
        SCRL_RD: begin
          state_q <= SCRL_WR;
          addr_q  <= AW'(addr_q - ROW_BYTES);
          we_q    <= 1'b1;
        end
        SCRL_WR: begin
          if (addr_q == COPY_LAST) begin
            state_q <= FILL_C;
            addr_q  <= AW'(addr_q + 1'b1);
            wdata_q <= FILL;
            we_q    <= 1'b1;
          end else begin
            state_q <= SCRL_RD;
            addr_q  <= AW'(addr_q + ROW_BYTES + 1'b1);
          end
        end
        FILL_C: begin
          state_q <= FILL_A;
          addr_q  <= AW'(addr_q + 1'b1);
          wdata_q <= attr_q;
          we_q    <= 1'b1;
        end
        FILL_A: begin
          if (addr_q == LAST_ADDR) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            if (ff_q) begin
              ff_q     <= 1'b0;
              row_q    <= '0;
              col_q    <= '0;
              cursor_q <= '0;
            end
          end else begin
            state_q <= FILL_C;
            addr_q  <= AW'(addr_q + 1'b1);
            wdata_q <= FILL;
            we_q    <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Copy data arrives from the RAM one cycle after the read, so it bypasses the register.
  assign mem_wdata   = (state_q == SCRL_WR) ? mem_rdata : wdata_q;
  assign mem_address = addr_q;
  assign mem_we      = we_q;
  assign busy        = busy_q;
  assign tx_ready    = ready_q;
  assign cursor      = cursor_q;

endmodule

// File: tb/tb_text_console_writer.sv
// Directed bench for text_console_writer with a behavioural text RAM.
module tb_text_console_writer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [7:0]  tx_data;
  logic [7:0]  tx_attr;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic [10:0] cursor;
  logic [12:0] mem_address;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata;

  logic [7:0]  ram [0:4095];
  logic        preload = 1'b0;
  int          wcount = 0;
  logic [12:0] last_wa = '0;
  logic        hi_write = 1'b0;

  int checks = 0;
  int errors = 0;
  int bad, busy_n, cur_bad, n, w0;

  text_console_writer dut (
    .clock(clock), .reset_n(reset_n),
    .tx_data(tx_data), .tx_attr(tx_attr), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .cursor(cursor),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] pat(input int a);
    return 8'((a / 160) * 9 + (a % 160));
  endfunction

  // Synchronous-read RAM model plus a write monitor.
  always @(posedge clock) begin
    mem_rdata <= ram[mem_address[11:0]];
    if (preload) begin
      for (int a = 0; a < 4000; a++) ram[a] <= pat(a);
    end else if (mem_we) begin
      ram[mem_address[11:0]] <= mem_wdata;
    end
    if (mem_we) begin
      wcount  <= wcount + 1;
      last_wa <= mem_address;
      if (mem_address >= 13'hFA0) hi_write <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input int limit);
    int k;
    k = 0;
    while (tx_ready !== 1'b1 && k < limit) begin
      @(negedge clock);
      k++;
    end
    chk("ready_timeout", 32'(tx_ready), 32'd1);
  endtask

  task automatic accept(input logic [7:0] d, input logic [7:0] a);
    tx_data  = d;
    tx_attr  = a;
    tx_valid = 1'b1;
    @(negedge clock);
    tx_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic [7:0] a);
    accept(d, a);
    wait_ready(9000);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n  = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    tx_attr  = '0;
    repeat (3) @(negedge clock);
    chk("rst_ready", 32'(tx_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cursor", 32'(cursor), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", 32'(mem_address), 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("ready_after_rst", 32'(tx_ready), 32'd1);

    // Single printable character
    accept(8'h41, 8'h17);
    chk("a_we1", 32'(mem_we), 32'd1);
    chk("a_addr1", 32'(mem_address), 32'h000);
    chk("a_data1", 32'(mem_wdata), 32'h41);
    chk("a_rdy1", 32'(tx_ready), 32'd0);
    @(negedge clock);
    chk("a_we2", 32'(mem_we), 32'd1);
    chk("a_addr2", 32'(mem_address), 32'h001);
    chk("a_data2", 32'(mem_wdata), 32'h17);
    chk("a_rdy2", 32'(tx_ready), 32'd0);
    @(negedge clock);
    chk("a_rdy3", 32'(tx_ready), 32'd1);
    chk("a_cursor", 32'(cursor), 32'd1);
    chk("a_we3", 32'(mem_we), 32'd0);
    chk("a_ram0", 32'(ram[0]), 32'h41);
    chk("a_ram1", 32'(ram[1]), 32'h17);

    // Move to row 3 col 5, then CR / LF / BS
    repeat (3) send(8'h0A, 8'h07);
    repeat (4) send(8'h62, 8'h07);
    chk("pos_245", 32'(cursor), 32'd245);
    w0 = wcount;
    send(8'h0D, 8'h07);
    chk("cr", 32'(cursor), 32'd240);
    send(8'h0A, 8'h07);
    chk("lf", 32'(cursor), 32'd320);
    send(8'h08, 8'h07);
    chk("bs_col0", 32'(cursor), 32'd320);
    chk("ctl_nowrite", 32'(wcount), 32'(w0));
    send(8'h63, 8'h07);
    chk("c_cursor", 32'(cursor), 32'd321);
    chk("c_lastwa", 32'(last_wa), 32'd641);
    send(8'h08, 8'h07);
    chk("bs_col1", 32'(cursor), 32'd320);

    // Form feed clears the whole screen
    accept(8'h0C, 8'h07);
    bad = 0;
    busy_n = 0;
    for (int i = 0; i < 4000; i++) begin
      if (mem_we !== 1'b1 || mem_address !== 13'(i) ||
          mem_wdata !== ((i % 2 == 1) ? 8'h07 : 8'h20)) bad++;
      if (busy === 1'b1) busy_n++;
      @(negedge clock);
    end
    chk("ff_seq", 32'(bad), 32'd0);
    chk("ff_busy_cycles", 32'(busy_n), 32'd4000);
    chk("ff_busy_end", 32'(busy), 32'd0);
    chk("ff_ready", 32'(tx_ready), 32'd1);
    chk("ff_cursor", 32'(cursor), 32'd0);
    chk("ff_we_end", 32'(mem_we), 32'd0);
    bad = 0;
    for (int a = 0; a < 4000; a++)
      if (ram[a] !== ((a % 2 == 1) ? 8'h07 : 8'h20)) bad++;
    chk("ff_ram", 32'(bad), 32'd0);

    // A full row of characters wraps to the next row
    repeat (80) send(8'h78, 8'h1E);
    chk("wrap_cursor", 32'(cursor), 32'd80);
    chk("wrap_lastwa", 32'(last_wa), 32'h09F);
    chk("wrap_ram_c", 32'(ram[158]), 32'h78);
    chk("wrap_ram_a", 32'(ram[159]), 32'h1E);

    // Scroll from the bottom row
    repeat (23) send(8'h0A, 8'h07);
    chk("bottom_cursor", 32'(cursor), 32'd1920);
    preload = 1'b1;
    @(negedge clock);
    preload = 1'b0;
    accept(8'h0A, 8'h2C);
    busy_n = 0;
    cur_bad = 0;
    n = 0;
    while (busy === 1'b1 && n < 9000) begin
      busy_n++;
      if (cursor !== 11'd1920) cur_bad++;
      @(negedge clock);
      n++;
    end
    chk("scroll_busy_cycles", 32'(busy_n), 32'd7840);
    chk("scroll_ready", 32'(tx_ready), 32'd1);
    chk("scroll_cursor", 32'(cursor), 32'd1920);
    chk("scroll_cursor_stable", 32'(cur_bad), 32'd0);
    bad = 0;
    for (int a = 0; a < 3840; a++)
      if (ram[a] !== pat(a + 160)) bad++;
    chk("scroll_rows", 32'(bad), 32'd0);
    bad = 0;
    for (int a = 3840; a < 4000; a++)
      if (ram[a] !== ((a % 2 == 1) ? 8'h2C : 8'h20)) bad++;
    chk("scroll_fill", 32'(bad), 32'd0);
    chk("no_high_write", 32'(hi_write), 32'd0);

    // Reset in the middle of a scroll
    accept(8'h0A, 8'h05);
    repeat (1000) @(negedge clock);
    chk("mid_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    @(negedge clock);
    chk("mrst_we", 32'(mem_we), 32'd0);
    chk("mrst_cursor", 32'(cursor), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    w0 = wcount;
    reset_n = 1'b1;
    @(negedge clock);
    chk("mrst_ready", 32'(tx_ready), 32'd1);
    repeat (20) @(negedge clock);
    chk("mrst_nowrite", 32'(wcount), 32'(w0));
    send(8'h5A, 8'h07);
    chk("mrst_char_addr", 32'(last_wa), 32'd1);
    chk("mrst_char_cursor", 32'(cursor), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/text_console_writer.md
Name: text_console_writer

Overview:
- Teletype-style writer for the 80x25 text buffer that the video card scans out. Writer side of the shared text RAM.
- Accepts a byte stream from the CPU/debug path and interprets control codes.
- Stores character/attribute pairs at byte address 2*pos (char) and 2*pos+1 (attr). Scrolls the buffer and clears the screen by itself.
- Drives the linear cursor position that the video card uses to display the cursor.

Parameters:
- COLS, 80, characters per row.
- ROWS, 25, rows on screen.
- FILL, 8'h20, character written when clearing cells.

Ports:
- clock  in  1  system clock (25 MHz pixel clock domain).
- reset_n  in  1  synchronous, active-low reset.
- tx_data  in  8  byte to print or control code.
- tx_attr  in  8  attribute for tx_data: bg in [7:4], fg in [3:0].
- tx_valid  in  1  tx_data/tx_attr valid.
- tx_ready  out  1  writer idle; the byte is accepted on tx_valid && tx_ready.
- busy  out  1  scroll or clear in progress.
- cursor  out  11  linear cursor position, row*COLS+col, range 0..1999.
- mem_address  out  13  text RAM byte address; only 0x000..0xF9F are used.
- mem_wdata  out  8  write data.
- mem_we  out  1  write strobe, one byte per cycle.
- mem_rdata  in  8  RAM read data, valid 1 cycle after mem_address is presented.

Behaviour:
- One clock; reset is synchronous and active-low (reset_n sampled on posedge clock).
- Reset values:
  - tx_ready=0 during reset, 1 in the first cycle after reset_n rises.
  - busy=0, cursor=0, mem_we=0, mem_address=0, mem_wdata=0.
  - Internal row=0, col=0, state=IDLE.
- Reset mid-operation aborts immediately: no further writes, cursor=0. RAM contents are left as they are.
- Byte accepted in IDLE when tx_valid=1. tx_data and tx_attr are latched that cycle. tx_ready=1 only in IDLE.
- States: IDLE, WCHR, WATR, SCRL_RD, SCRL_WR, FILL_C, FILL_A.
- Printable byte (any code other than 08/0A/0D/0C):
  - Accept cycle N.
  - N+1, WCHR: mem_we=1, address=2*cursor, data=char.
  - N+2, WATR: mem_we=1, address=2*cursor+1, data=attr.
  - col advances at end of N+2.
  - If col was COLS-1: col=0 and a line feed follows.
  - Otherwise IDLE with tx_ready=1 at N+3.
- 0x0D (CR): col=0; IDLE next cycle; no RAM write.
- 0x08 (BS): col=col-1 if col>0, else unchanged; row is never changed; no RAM write.
- Line feed (0x0A, or wrap after column COLS-1):
  - If row<ROWS-1: row+1, IDLE next cycle. Col is unchanged for 0x0A; it is 0 after a wrap.
  - If row=ROWS-1: row stays, enter scroll.
- Scroll: busy=1.
  - For d = 0 .. 2*COLS*(ROWS-1)-1, in order:
    - SCRL_RD: mem_address=d+2*COLS, we=0.
    - SCRL_WR: mem_address=d, mem_wdata=mem_rdata, we=1.
  - Then the last row is filled: for each cell c of row ROWS-1, FILL_C writes FILL at 2c, then FILL_A writes the latched attr at 2c+1.
  - Total 2*3840+160 = 7840 cycles, then IDLE.
- 0x0C (FF): busy=1; all 2000 cells filled (FILL/attr pairs, 4000 cycles, ascending address). Cursor=0 at the end of the fill.
- Source address is always greater than destination address, so the ascending copy is overlap-safe.
- cursor changes only in the cycle that row/col are updated, never during a scroll. Width arithmetic: row*COLS+col computed in 11 bits, no overflow at 1999.
- mem_we is never asserted outside WCHR/WATR/SCRL_WR/FILL_*. It is never high for addresses >= 0xFA0.
- tx_valid while busy or not in IDLE is ignored, not queued. The producer must hold it.

Test Plan:
- Reset, send 'A' (0x41) with attr 0x17 → writes 0x000←0x41 at N+1 and 0x001←0x17 at N+2; tx_ready low for N+1..N+2; cursor=1 at N+3.
- Cursor at col 5 row 3 (cursor=245): send 0x0D → cursor=240; then 0x0A → cursor=320; then 0x08 at col 0 → cursor stays 320; no mem_we throughout.
- Print 80 'x' from cursor 0 → the 80th write goes to 0x09E/0x09F; cursor=80 afterwards.
- Preload RAM rows with distinct patterns, cursor=1920, send 0x0A → busy for exactly 7840 cycles; row k now holds old row k+1; row 24 = 0x20/attr pairs; cursor=1920; tx_ready back after busy drops.
- Send 0x0C with attr 0x07 → 4000 writes ascending 0x000..0xF9F alternating 0x20/0x07; cursor=0; no writes ≥0xFA0.
- Assert reset_n=0 for one cycle in the middle of a scroll → mem_we=0 from the next cycle, cursor=0, busy=0, tx_ready=1 after release.
